// File: rtl/pcileech_tlp_pkg.sv
// pcileech_tlp_pkg: shared types for the parametrised TLP packer.
// Each packed entry holds one 64-bit stream beat plus two flag bits:
// {keep_dw2, last, DW2, DW1}.
package pcileech_tlp_pkg;

    localparam int TLP_QW_W  = 66;
    localparam int QW_DW1_LO = 0;
    localparam int QW_DW2_LO = 32;
    localparam int QW_LAST   = 64;
    localparam int QW_KEEP2  = 65;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FILL  = 2'd1,
        FULL  = 2'd2
    } slot_state_t;

    // Build one storage entry from a stream beat.
    function automatic logic [TLP_QW_W-1:0] pack_qw(input logic        keep2,
                                                    input logic        last,
                                                    input logic [63:0] data);
        logic [TLP_QW_W-1:0] q;
        q                    = '0;
        q[QW_DW1_LO +: 32]   = data[31:0];
        q[QW_DW2_LO +: 32]   = data[63:32];
        q[QW_LAST]           = last;
        q[QW_KEEP2]          = keep2;
        return q;
    endfunction

endpackage

// File: rtl/pcileech_tlp_packer_slot.sv
// pcileech_tlp_packer_slot: one ping-pong buffer of MAX_QW entries.
// Clearing zeroes every entry, so a short TLP always reads back with
// zero padding above its last beat.
module pcileech_tlp_packer_slot
    import pcileech_tlp_pkg::*;
#(
    parameter int MAX_QW = 18
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       wr_en,
    input  logic                       complete,
    input  logic [$clog2(MAX_QW)-1:0]  wr_idx,
    input  logic [TLP_QW_W-1:0]        wr_entry,
    output logic [1:0]                 state,
    output logic [TLP_QW_W*MAX_QW-1:0] data
);

    slot_state_t                      st;
    logic [MAX_QW-1:0][TLP_QW_W-1:0]  mem;

    assign state = st;
    assign data  = mem;

    // Storage and state: clear wins over write; completion marks FULL.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            mem <= '0;
            st  <= EMPTY;
        end else begin
            if (wr_en) begin
                mem[wr_idx] <= wr_entry;
                if (st == EMPTY)
                    st <= FILL;
            end
            if (complete)
                st <= FULL;
        end
    end

endmodule

// File: rtl/pcileech_tlp_packer.sv
// pcileech_tlp_packer: packs 64-bit AXI-stream TLP beats into two
// ping-pong slots of MAX_QW entries and hands them to a sink via the
// m_has_data / m_req_data / m_valid handshake.
// Option macro PCILEECH_TLP_PACKER_DROP_OVERSIZE_EN: when defined, an
// oversize TLP is dropped and counted; otherwise it is truncated to
// MAX_QW entries with the last flag forced on the final entry.
module pcileech_tlp_packer
    import pcileech_tlp_pkg::*;
#(
    parameter int MAX_QW = 18
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [63:0]                s_data,
    input  logic [7:0]                 s_keep,
    input  logic                       s_last,
    input  logic                       s_valid,
    output logic                       s_ready,
    output logic [TLP_QW_W*MAX_QW-1:0] m_data,
    output logic                       m_valid,
    output logic                       m_has_data,
    input  logic                       m_req_data,
    output logic [15:0]                drop_cnt
);

    localparam int BW = $clog2(MAX_QW + 1);
    localparam int IW = $clog2(MAX_QW);

    logic                        wr_sel;
    logic                        rd_sel;
    logic                        skip;
    logic [BW-1:0]               bcnt;
    logic [1:0]                  sl_state [2];
    logic [TLP_QW_W*MAX_QW-1:0]  sl_data  [2];
    logic [1:0]                  sl_wr;
    logic [1:0]                  sl_cmp;
    logic [1:0]                  sl_clr;
    logic                        beat;
    logic                        wr_beat;
    logic                        at_end;
    logic                        oversize;
    logic                        trunc;
    logic                        rel;
    logic [TLP_QW_W-1:0]         entry;
    logic                        unused_keep;

    // Only the DW2 keep bit carries information on a 64-bit beat.
    assign unused_keep = ^{s_keep[7:5], s_keep[3:0]};

    // Ready comes from registered state only, so a slot freed this cycle
    // cannot also receive a beat this cycle.
    assign s_ready    = rst_n && (skip || sl_state[wr_sel] != FULL);
    assign m_has_data = sl_state[rd_sel] == FULL;

    assign beat     = s_valid && s_ready;
    assign wr_beat  = beat && !skip;
    assign at_end   = bcnt == BW'(MAX_QW - 1);
    assign oversize = wr_beat && at_end && !s_last;
    assign rel      = m_req_data && m_has_data;

`ifdef PCILEECH_TLP_PACKER_DROP_OVERSIZE_EN
    assign trunc = 1'b0;
`else
    assign trunc = oversize;
`endif

    assign entry = pack_qw(s_keep[4], s_last | trunc, s_data);

    // Per-slot controls: writes target wr_sel, releases target rd_sel.
    always_comb begin
        sl_wr          = '0;
        sl_cmp         = '0;
        sl_clr         = '0;
        sl_wr[wr_sel]  = wr_beat;
        sl_cmp[wr_sel] = wr_beat && (s_last || trunc);
        sl_clr[rd_sel] = rel;
`ifdef PCILEECH_TLP_PACKER_DROP_OVERSIZE_EN
        sl_clr[wr_sel] = sl_clr[wr_sel] | oversize;
`endif
    end

    for (genvar g = 0; g < 2; g++) begin : g_slot
        pcileech_tlp_packer_slot #(
            .MAX_QW   (MAX_QW)
        ) u_slot (
            .clk      (clk),
            .rst_n    (rst_n),
            .clr      (sl_clr[g]),
            .wr_en    (sl_wr[g]),
            .complete (sl_cmp[g]),
            .wr_idx   (bcnt[IW-1:0]),
            .wr_entry (entry),
            .state    (sl_state[g]),
            .data     (sl_data[g])
        );
    end

    // Write side: beat counter, slot selection and oversize skip.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_sel <= 1'b0;
            bcnt   <= '0;
            skip   <= 1'b0;
        end else begin
            if (beat && skip && s_last)
                skip <= 1'b0;
            if (oversize) begin
                bcnt <= '0;
                skip <= 1'b1;
`ifndef PCILEECH_TLP_PACKER_DROP_OVERSIZE_EN
                wr_sel <= !wr_sel;
`endif
            end else if (wr_beat && s_last) begin
                bcnt   <= '0;
                wr_sel <= !wr_sel;
            end else if (wr_beat) begin
                bcnt <= bcnt + BW'(1);
            end
        end
    end

    // Read side: deliver the oldest FULL slot one cycle after a request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_sel  <= 1'b0;
            m_valid <= 1'b0;
            m_data  <= '0;
        end else begin
            m_valid <= rel;
            if (rel) begin
                m_data <= sl_data[rd_sel];
                rd_sel <= !rd_sel;
            end
        end
    end

`ifdef PCILEECH_TLP_PACKER_DROP_OVERSIZE_EN
    // Saturating count of dropped oversize TLPs.
    always_ff @(posedge clk) begin
        if (!rst_n)
            drop_cnt <= '0;
        else if (oversize && drop_cnt != 16'hFFFF)
            drop_cnt <= drop_cnt + 16'd1;
    end
`else
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_pcileech_tlp_packer.sv
// tb_pcileech_tlp_packer: directed bench with hand-derived expectations.
// dut uses MAX_QW=18, dut6 uses MAX_QW=6 for the oversize cases.
module tb_pcileech_tlp_packer;

    localparam int W  = 66;
    localparam int QW = 18;
    localparam int QS = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [63:0]     s_data, s_data6;
    logic [7:0]      s_keep, s_keep6;
    logic            s_last, s_last6, s_valid, s_valid6;
    logic            s_ready, s_ready6;
    logic [W*QW-1:0] m_data;
    logic [W*QS-1:0] m_data6;
    logic            m_valid, m_valid6, m_has_data, m_has_data6;
    logic            m_req_data, m_req_data6;
    logic [15:0]     drop_cnt, drop_cnt6;

    int checks = 0;
    int failures = 0;

    pcileech_tlp_packer #(.MAX_QW(QW)) dut (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_keep(s_keep),
        .s_last(s_last), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_has_data(m_has_data),
        .m_req_data(m_req_data), .drop_cnt(drop_cnt)
    );

    pcileech_tlp_packer #(.MAX_QW(QS)) dut6 (
        .clk(clk), .rst_n(rst_n), .s_data(s_data6), .s_keep(s_keep6),
        .s_last(s_last6), .s_valid(s_valid6), .s_ready(s_ready6),
        .m_data(m_data6), .m_valid(m_valid6), .m_has_data(m_has_data6),
        .m_req_data(m_req_data6), .drop_cnt(drop_cnt6)
    );

    function automatic logic [63:0] mk(input int id, input int b);
        logic [15:0] b16;
        logic [7:0]  i8;
        b16 = b[15:0];
        i8  = id[7:0];
        return {8'hA5, i8, b16, 8'h5A, i8, b16 + 16'h0100};
    endfunction

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Entries below n carry beat data; the last one (or entry nq-1 when
    // truncated) has last=1; everything above is zero.
    task automatic chk_tlp(input logic [W*QW-1:0] md, input int nq, input int id,
                           input int n, input logic [7:0] lkeep);
        logic [W-1:0] e;
        for (int i = 0; i < nq; i++) begin
            e = '0;
            if (i < n) begin
                e[63:0] = mk(id, i);
                e[64]   = (i == n - 1) || (i == nq - 1);
                e[65]   = (i == n - 1) ? lkeep[4] : 1'b1;
            end
            chk($sformatf("tlp%0d_e%0d", id, i), 128'(md[i*W +: W]), 128'(e));
        end
    endtask

    task automatic send18(input int id, input int n, input logic [7:0] lkeep);
        int w;
        for (int b = 0; b < n; b++) begin
            @(negedge clk);
            s_valid = 1'b1;
            s_data  = mk(id, b);
            s_last  = (b == n - 1);
            s_keep  = (b == n - 1) ? lkeep : 8'hFF;
            w = 0;
            while (!s_ready && w < 50) begin
                @(negedge clk);
                w++;
            end
            if (w >= 50) chk($sformatf("tlp%0d_rdy_tmo", id), 128'(0), 128'(1));
            @(posedge clk);
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send6(input int id, input int n, output int stalls, output logic hd_seen);
        stalls  = 0;
        hd_seen = 1'b0;
        for (int b = 0; b < n; b++) begin
            @(negedge clk);
            s_valid6 = 1'b1;
            s_data6  = mk(id, b);
            s_last6  = (b == n - 1);
            s_keep6  = 8'hFF;
            hd_seen  = hd_seen | m_has_data6;
            while (!s_ready6 && stalls < 50) begin
                @(negedge clk);
                stalls++;
            end
            @(posedge clk);
        end
        @(negedge clk);
        hd_seen  = hd_seen | m_has_data6;
        s_valid6 = 1'b0;
        s_last6  = 1'b0;
    endtask

    task automatic req18(input int id, input int n, input logic [7:0] lkeep);
        @(negedge clk);
        m_req_data = 1'b1;
        @(negedge clk);
        m_req_data = 1'b0;
        chk($sformatf("tlp%0d_valid", id), 128'(m_valid), 128'(1));
        chk_tlp(m_data, QW, id, n, lkeep);
        @(negedge clk);
        chk($sformatf("tlp%0d_valid_once", id), 128'(m_valid), 128'(0));
        chk($sformatf("tlp%0d_held", id), 128'(m_data[63:0]), 128'(mk(id, 0)));
    endtask

    task automatic req6(input int id, input int n);
        logic [W*QW-1:0] md;
        @(negedge clk);
        m_req_data6 = 1'b1;
        @(negedge clk);
        m_req_data6 = 1'b0;
        md = '0;
        md[W*QS-1:0] = m_data6;
        chk($sformatf("q6_tlp%0d_valid", id), 128'(m_valid6), 128'(1));
        chk_tlp(md, QS, id, n, 8'hFF);
        chk($sformatf("q6_tlp%0d_hd_after", id), 128'(m_has_data6), 128'(0));
    endtask

    initial begin
        int   stalls, vcnt, bad;
        logic hd_seen, prev_hd;

        s_data = '0; s_keep = '0; s_last = 1'b0; s_valid = 1'b0; m_req_data = 1'b0;
        s_data6 = '0; s_keep6 = '0; s_last6 = 1'b0; s_valid6 = 1'b0; m_req_data6 = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_s_ready", 128'(s_ready), 128'(0));
        chk("rst_s_ready6", 128'(s_ready6), 128'(0));
        chk("rst_m_valid", 128'(m_valid), 128'(0));
        chk("rst_has_data", 128'(m_has_data), 128'(0));
        chk("rst_m_data", 128'(m_data[127:0]), 128'(0));
        chk("rst_drop", 128'(drop_cnt), 128'(0));
        rst_n = 1'b1;
        #1;
        chk("post_rst_s_ready", 128'(s_ready), 128'(1));

        // 3-beat TLP, keep 0F on last beat, request two cycles later
        send18(1, 3, 8'h0F);
        chk("t1_has_data", 128'(m_has_data), 128'(1));
        @(negedge clk);
        req18(1, 3, 8'h0F);
        chk("t1_has_data_after", 128'(m_has_data), 128'(0));

        // Three 2-beat TLPs with an idle sink
        send18(2, 2, 8'hFF);
        send18(3, 2, 8'hFF);
        chk("t2_ready_low", 128'(s_ready), 128'(0));
        chk("t2_has_data", 128'(m_has_data), 128'(1));
        fork
            send18(4, 2, 8'hFF);
            begin
                repeat (2) @(negedge clk);
                chk("t2_ready_still_low", 128'(s_ready), 128'(0));
                m_req_data = 1'b1;
                @(negedge clk);
                m_req_data = 1'b0;
                chk("t2_first_valid", 128'(m_valid), 128'(1));
                chk_tlp(m_data, QW, 2, 2, 8'hFF);
                chk("t2_ready_rise", 128'(s_ready), 128'(1));
            end
        join
        @(negedge clk);
        req18(3, 2, 8'hFF);
        req18(4, 2, 8'hFF);
        chk("t2_empty", 128'(m_has_data), 128'(0));

        // Reset mid-TLP with one TLP buffered
        send18(5, 4, 8'hFF);
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            s_valid = 1'b1; s_data = mk(6, b); s_keep = 8'hFF; s_last = 1'b0;
            @(posedge clk);
        end
        @(negedge clk);
        s_valid = 1'b0;
        rst_n   = 1'b0;
        @(negedge clk);
        chk("mid_rst_s_ready", 128'(s_ready), 128'(0));
        chk("mid_rst_m_valid", 128'(m_valid), 128'(0));
        chk("mid_rst_has_data", 128'(m_has_data), 128'(0));
        chk("mid_rst_m_data", 128'(m_data[127:0]), 128'(0));
        chk("mid_rst_drop", 128'(drop_cnt), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mid_rst_ready_after", 128'(s_ready), 128'(1));
        send18(7, 2, 8'hFF);
        req18(7, 2, 8'hFF);
        send18(8, 1, 8'h0F);
        req18(8, 1, 8'h0F);

        // Request held high: one m_valid per TLP, none without data
        @(negedge clk);
        m_req_data = 1'b1;
        vcnt = 0;
        bad = 0;
        prev_hd = m_has_data;
        fork
            begin
                send18(9, 2, 8'hFF);
                send18(10, 2, 8'hFF);
            end
            begin
                repeat (20) begin
                    @(negedge clk);
                    if (m_valid) vcnt++;
                    if (m_valid && !prev_hd) bad++;
                    prev_hd = m_has_data;
                end
            end
        join
        m_req_data = 1'b0;
        chk("hold_valid_count", 128'(vcnt), 128'(2));
        chk("hold_spurious", 128'(bad), 128'(0));
        chk("hold_m_data", 128'(m_data[63:0]), 128'(mk(10, 0)));
        chk("drop18", 128'(drop_cnt), 128'(0));

        // MAX_QW=6, 8-beat oversize TLP
        send6(11, 8, stalls, hd_seen);
        chk("ovs_stalls", 128'(stalls), 128'(0));
`ifdef PCILEECH_TLP_PACKER_DROP_OVERSIZE_EN
        chk("ovs_hd_seen", 128'(hd_seen), 128'(0));
        chk("ovs_drop", 128'(drop_cnt6), 128'(1));
        @(negedge clk);
        chk("ovs_hd", 128'(m_has_data6), 128'(0));
`else
        chk("ovs_hd_seen", 128'(hd_seen), 128'(1));
        chk("ovs_drop", 128'(drop_cnt6), 128'(0));
        req6(11, 8);
`endif
        send6(12, 2, stalls, hd_seen);
        chk("ovs_next_has_data", 128'(m_has_data6), 128'(1));
        req6(12, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
